// File: rtl/ysyx_22041412_csr_req_pkg.sv
// Shared definitions for the EXU-side CSR request initiator: CSR addresses,
// responder index codes, func3 op codes and the sequencer state encoding.
package ysyx_22041412_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0] IDX_MRET    = 3'd0;
    localparam logic [2:0] IDX_ECALL   = 3'd1;
    localparam logic [2:0] IDX_MSTATUS = 3'd2;
    localparam logic [2:0] IDX_MTVEC   = 3'd3;
    localparam logic [2:0] IDX_MEPC    = 3'd4;
    localparam logic [2:0] IDX_MCAUSE  = 3'd5;

    typedef enum logic [2:0] {
        F3_SYSTEM = 3'b000,
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } csr_f3_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_TRAP,
        S_DONE
    } state_t;

    // The immediate forms carry a 5-bit zero-extended uimm in the rs1 field.
    function automatic logic f3_is_imm(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/ysyx_22041412_csr_req_if.sv
// Request bus between the EXU CSR initiator (master) and the CSR responder (slave).
interface ysyx_22041412_csr_req_if #(
    parameter int XLEN = 64
);
    logic            en;
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [2:0]      addr;
    logic [2:0]      func3;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ready;

    modport master (
        output en, valid, pc, addr, func3, wdata,
        input  rdata, ready
    );

    modport slave (
        input  en, valid, pc, addr, func3, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/ysyx_22041412_csr_req_amap.sv
// Combinational decode of a 12-bit machine CSR address into the responder's
// 3-bit index, with a flag saying whether the address is implemented.
module ysyx_22041412_csr_amap
    import ysyx_22041412_csr_pkg::*;
(
    input  logic [11:0] i_csr,
    output logic [2:0]  o_idx,
    output logic        o_legal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_idx   = IDX_MRET;
        o_legal = 1'b0;
        case (i_csr)
            CSR_MSTATUS: begin o_idx = IDX_MSTATUS; o_legal = 1'b1; end
            CSR_MTVEC:   begin o_idx = IDX_MTVEC;   o_legal = 1'b1; end
            CSR_MEPC:    begin o_idx = IDX_MEPC;    o_legal = 1'b1; end
            CSR_MCAUSE:  begin o_idx = IDX_MCAUSE;  o_legal = 1'b1; end
            default:     ;
        endcase
    end

endmodule

// File: rtl/ysyx_22041412_csr_req.sv
// EXU-side CSR request initiator: sequences the responder's read-then-write
// handshake for CSR ops, or a single trap request for ecall/mret, with timeout.
module ysyx_22041412_csr_req
    import ysyx_22041412_csr_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
)(
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [11:0]             in_csr,
    input  logic [2:0]              in_func3,
    input  logic                    in_mret,
    input  logic [4:0]              in_rs1,
    input  logic [XLEN-1:0]         in_rs1_val,
    input  logic [4:0]              in_rd,

    ysyx_22041412_csr_req_if.master csr,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_rd,
    output logic                    out_rd_we,
    output logic [XLEN-1:0]         out_rd_data,
    output logic                    out_redirect,
    output logic [XLEN-1:0]         out_redirect_pc,
    output logic                    out_err
);

    localparam logic [4:0] CNT_LIMIT = 5'(TIMEOUT - 1);

    state_t          r_state;
    logic            r_req;
    logic [XLEN-1:0] r_pc;
    logic [2:0]      r_addr;
    logic [2:0]      r_func3;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_cnt;
    logic            r_out_valid;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic [XLEN-1:0] r_rd_data;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_err;

    logic [2:0]      w_idx;
    logic            w_legal;
    logic            w_accept;
    logic            w_is_sys;
    logic            w_limit;
    logic [XLEN-1:0] w_operand;

    ysyx_22041412_csr_amap u_amap (
        .i_csr   (in_csr),
        .o_idx   (w_idx),
        .o_legal (w_legal)
    );

    // A ready still high from the previous request must not be mistaken for a new one.
    assign in_ready  = (r_state == S_IDLE) && !csr.ready && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_is_sys  = (in_func3 == F3_SYSTEM);
    assign w_limit   = (r_cnt == CNT_LIMIT);
    assign w_operand = f3_is_imm(in_func3) ? XLEN'(in_rs1) : in_rs1_val;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every branch reads the pre-edge state.
        if (rst) begin
            r_state       <= S_IDLE;
            r_req         <= 1'b0;
            r_pc          <= '0;
            r_addr        <= '0;
            r_func3       <= '0;
            r_wdata       <= '0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_rd          <= '0;
            r_rd_we       <= 1'b0;
            r_rd_data     <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_err         <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pc          <= in_pc;
                        r_addr        <= w_is_sys ? (in_mret ? IDX_MRET : IDX_ECALL) : w_idx;
                        r_func3       <= in_func3;
                        r_wdata       <= w_operand;
                        r_rd          <= in_rd;
                        r_cnt         <= '0;
                        r_rd_we       <= 1'b0;
                        r_rd_data     <= '0;
                        r_redirect    <= 1'b0;
                        r_redirect_pc <= '0;
                        r_err         <= 1'b0;
                        if (w_is_sys) begin
                            r_req   <= 1'b1;
                            r_state <= S_TRAP;
                        end else if (w_legal) begin
                            r_req   <= 1'b1;
                            r_state <= S_RD;
                        end else begin
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_RD: begin
                    if (csr.ready) begin
                        r_rd_data <= csr.rdata;
                        r_state   <= S_WR;
                    end else if (w_limit) begin
                        r_req       <= 1'b0;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                // The responder commits the write on the edge that ends this state.
                S_WR: begin
                    r_req       <= 1'b0;
                    r_rd_we     <= (r_rd != 5'd0);
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_TRAP: begin
                    if (csr.ready) begin
                        r_req         <= 1'b0;
                        r_redirect_pc <= csr.rdata;
                        r_redirect    <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end else if (w_limit) begin
                        r_req       <= 1'b0;
                        r_err       <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign csr.en          = r_req;
    assign csr.valid       = r_req;
    assign csr.pc          = r_pc;
    assign csr.addr        = r_addr;
    assign csr.func3       = r_func3;
    assign csr.wdata       = r_wdata;

    assign out_valid       = r_out_valid;
    assign out_rd          = r_rd;
    assign out_rd_we       = r_rd_we;
    assign out_rd_data     = r_rd_data;
    assign out_redirect    = r_redirect;
    assign out_redirect_pc = r_redirect_pc;
    assign out_err         = r_err;

endmodule

// File: tb/tb_ysyx_22041412_csr_req.sv
// Bench for the CSR request initiator: a behavioural CSR responder plus an
// instruction-level reference model of the machine CSRs drive directed and random ops.
module tb_ysyx_22041412_csr_req;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [11:0] in_csr;
    logic [2:0]  in_func3;
    logic        in_mret;
    logic [4:0]  in_rs1;
    logic [63:0] in_rs1_val;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [63:0] out_rd_data;
    logic        out_redirect;
    logic [63:0] out_redirect_pc;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    int waitc;
    logic stable;

    ysyx_22041412_csr_req_if #(.XLEN(64)) csr_if ();

    ysyx_22041412_csr_req #(.XLEN(64), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_csr          (in_csr),
        .in_func3        (in_func3),
        .in_mret         (in_mret),
        .in_rs1          (in_rs1),
        .in_rs1_val      (in_rs1_val),
        .in_rd           (in_rd),
        .csr             (csr_if),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_rd          (out_rd),
        .out_rd_we       (out_rd_we),
        .out_rd_data     (out_rd_data),
        .out_redirect    (out_redirect),
        .out_redirect_pc (out_redirect_pc),
        .out_err         (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // CSR write semantics by func3 (RW/RS/RC and their immediate forms).
    function automatic logic [63:0] apply_op(input logic [2:0] f3, input logic [63:0] old_v,
                                             input logic [63:0] w);
        case (f3[1:0])
            2'b01:   return w;
            2'b10:   return old_v | w;
            2'b11:   return old_v & ~w;
            default: return old_v;
        endcase
    endfunction

    // Behavioural responder: index 2..5 = mstatus/mtvec/mepc/mcause; ready comes
    // resp_delay cycles after valid rises and then stays high while valid.
    logic [63:0] m_csr [0:7];
    logic        resp_ready;
    logic        resp_mute;
    logic        resp_phase;
    int          resp_delay;
    int          resp_cnt;

    always @(posedge clk) begin
        if (rst) begin
            resp_ready <= 1'b0;
            resp_phase <= 1'b0;
            resp_cnt   <= 0;
            for (int i = 0; i < 8; i++) m_csr[i] <= '0;
            m_csr[2] <= 64'ha00001800;
        end else begin
            resp_ready <= csr_if.valid && !resp_mute && (resp_cnt >= resp_delay - 1);
            resp_cnt   <= csr_if.valid ? resp_cnt + 1 : 0;
            if (!csr_if.valid) begin
                resp_phase <= 1'b0;
            end else if (resp_ready) begin
                if (csr_if.addr >= 3'd2) begin
                    if (resp_phase) begin
                        m_csr[csr_if.addr] <= apply_op(csr_if.func3, m_csr[csr_if.addr], csr_if.wdata);
                        resp_phase <= 1'b0;
                    end else begin
                        resp_phase <= 1'b1;
                    end
                end else if (csr_if.addr == 3'd1) begin
                    m_csr[4] <= csr_if.pc;
                    m_csr[5] <= 64'hb;
                end
            end
        end
    end

    assign csr_if.ready = resp_ready;
    assign csr_if.rdata = (csr_if.addr == 3'd0) ? m_csr[4] :
                          (csr_if.addr == 3'd1) ? m_csr[3] : m_csr[csr_if.addr];

    // Instruction-level reference copy of the machine CSRs.
    logic [63:0] ref_csr [0:7];

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_csr[i] = '0;
        ref_csr[2] = 64'ha00001800;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [63:0] pc, input logic [11:0] a12, input logic [2:0] f3,
                         input logic mret, input logic [4:0] rs1, input logic [63:0] rs1_val,
                         input logic [4:0] rd, input int hold);
        logic        sys, legal, req, tmo;
        logic [2:0]  idx;
        logic [63:0] opnd, e_rd_data, e_rpc;
        logic        e_err, e_we, e_redir;
        logic [140:0] snap;
        int          e_lat, lat;

        sys   = (f3 == 3'b000);
        legal = 1'b1;
        idx   = 3'd0;
        case (a12)
            12'h300: idx = 3'd2;
            12'h305: idx = 3'd3;
            12'h341: idx = 3'd4;
            12'h342: idx = 3'd5;
            default: legal = 1'b0;
        endcase
        opnd  = f3[2] ? {59'd0, rs1} : rs1_val;
        req   = sys || legal;
        tmo   = req && (resp_mute || (resp_delay + 1 > TIMEOUT));
        e_err = !req || tmo;
        e_we = 1'b0; e_redir = 1'b0; e_rd_data = '0; e_rpc = '0;
        if (tmo) begin
            e_lat = TIMEOUT + 1;
        end else if (!req) begin
            e_lat = 1;
        end else if (sys) begin
            e_lat   = resp_delay + 2;
            e_redir = 1'b1;
            e_rpc   = mret ? ref_csr[4] : ref_csr[3];
            if (!mret) begin
                ref_csr[4] = pc;
                ref_csr[5] = 64'hb;
            end
        end else begin
            e_lat     = resp_delay + 3;
            e_we      = (rd != 5'd0);
            e_rd_data = ref_csr[idx];
            ref_csr[idx] = apply_op(f3, ref_csr[idx], opnd);
        end
        if (sys) idx = mret ? 3'd0 : 3'd1;

        in_pc = pc; in_csr = a12; in_func3 = f3; in_mret = mret;
        in_rs1 = rs1; in_rs1_val = rs1_val; in_rd = rd; in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;

        if (req) begin
            check("req_en", 64'(csr_if.en), 64'd1);
            check("req_valid", 64'(csr_if.valid), 64'd1);
            check("req_addr", 64'(csr_if.addr), 64'(idx));
            check("req_func3", 64'(csr_if.func3), 64'(f3));
            check("req_wdata", csr_if.wdata, opnd);
            check("req_pc", csr_if.pc, pc);
        end else begin
            check("no_req", 64'(csr_if.valid), 64'd0);
        end

        lat = 1;
        stable = 1'b1;
        while (!out_valid && lat < 60) begin
            if (csr_if.valid && (csr_if.addr !== idx || csr_if.func3 !== f3 ||
                                 csr_if.wdata !== opnd || csr_if.pc !== pc)) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("req_stable", 64'(stable), 64'd1);
        check("latency", 64'(lat), 64'(e_lat));
        check("out_valid", 64'(out_valid), 64'd1);
        check("valid_low_done", 64'(csr_if.valid), 64'd0);
        check("in_ready_done", 64'(in_ready), 64'd0);
        check("out_err", 64'(out_err), 64'(e_err));
        check("out_rd_we", 64'(out_rd_we), 64'(e_we));
        check("out_redirect", 64'(out_redirect), 64'(e_redir));
        if (e_redir) check("redirect_pc", out_redirect_pc, e_rpc);
        if (!sys && req && !tmo) begin
            check("rd_data", out_rd_data, e_rd_data);
            check("out_rd", 64'(out_rd), 64'(rd));
        end

        snap = {out_valid, out_rd, out_rd_we, out_rd_data, out_redirect, out_redirect_pc, out_err};
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || snap !== {out_valid, out_rd, out_rd_we, out_rd_data,
                                               out_redirect, out_redirect_pc, out_err}) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 64'(stable), 64'd1);

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clr", 64'(out_valid), 64'd0);
        for (int i = 2; i < 6; i++) check("csr_state", m_csr[i], ref_csr[i]);
    endtask

    logic [2:0]  f3_tab [6]   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    logic [11:0] addr_tab [4] = '{12'h300, 12'h305, 12'h341, 12'h342};
    int          kind;
    logic [11:0] r_a12;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_csr = '0; in_func3 = '0; in_mret = 1'b0;
        in_rs1 = '0; in_rs1_val = '0; in_rd = '0;
        resp_mute = 1'b0; resp_delay = 1;
        ref_reset();

        repeat (3) @(negedge clk);
        check("in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_csr_valid", 64'(csr_if.valid), 64'd0);
        check("rst_csr_en", 64'(csr_if.en), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        check("rst_redirect", 64'(out_redirect), 64'd0);
        check("rst_rd_we", 64'(out_rd_we), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // csrrw mtvec, csrrsi mstatus, ecall, mret
        do_op(64'h80000000, 12'h305, 3'b001, 1'b0, 5'd0, 64'h80000100, 5'd5, 0);
        do_op(64'h80000004, 12'h300, 3'b110, 1'b0, 5'd8, 64'hdeadbeef, 5'd6, 0);
        check("mstatus_val", m_csr[2], 64'ha00001808);
        do_op(64'h80000040, 12'h000, 3'b000, 1'b0, 5'd0, 64'd0, 5'd0, 0);
        check("mepc_val", m_csr[4], 64'h80000040);
        check("mcause_val", m_csr[5], 64'hb);
        do_op(64'h80000100, 12'h302, 3'b000, 1'b1, 5'd0, 64'd0, 5'd0, 0);

        // illegal CSR, rd=0 write, silent responder, ready exactly at the count limit
        do_op(64'h80000044, 12'h7c0, 3'b010, 1'b0, 5'd1, 64'h1, 5'd9, 0);
        do_op(64'h80000048, 12'h342, 3'b001, 1'b0, 5'd0, 64'h55, 5'd0, 0);
        resp_mute = 1'b1;
        do_op(64'h8000004c, 12'h341, 3'b001, 1'b0, 5'd0, 64'h77, 5'd3, 0);
        resp_mute = 1'b0;
        resp_delay = TIMEOUT - 1;
        do_op(64'h80000050, 12'h342, 3'b010, 1'b0, 5'd0, 64'hf0, 5'd4, 0);
        resp_delay = TIMEOUT;
        do_op(64'h80000054, 12'h000, 3'b000, 1'b0, 5'd0, 64'd0, 5'd0, 0);
        resp_delay = 1;

        // result held for five cycles before acceptance
        do_op(64'h80000058, 12'h300, 3'b011, 1'b0, 5'd0, 64'h8, 5'd10, 5);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            resp_delay = $urandom_range(1, 3);
            if (kind == 0) begin
                do_op({$urandom, $urandom}, 12'h000, 3'b000, 1'b0, 5'd0, 64'd0, 5'd0,
                      $urandom_range(0, 3));
            end else if (kind == 1) begin
                do_op({$urandom, $urandom}, 12'h302, 3'b000, 1'b1, 5'd0, 64'd0, 5'd0,
                      $urandom_range(0, 3));
            end else if (kind == 2) begin
                r_a12 = 12'($urandom);
                while (r_a12 == 12'h300 || r_a12 == 12'h305 || r_a12 == 12'h341 || r_a12 == 12'h342)
                    r_a12 = 12'($urandom);
                do_op({$urandom, $urandom}, r_a12, f3_tab[$urandom_range(0, 5)], 1'b0,
                      5'($urandom), {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 3));
            end else begin
                do_op({$urandom, $urandom}, addr_tab[$urandom_range(0, 3)], f3_tab[$urandom_range(0, 5)],
                      1'b0, 5'($urandom), {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 3));
            end
        end
        resp_delay = 1;

        // reset while the read request is outstanding
        resp_mute = 1'b1;
        in_pc = 64'h80000200; in_csr = 12'h305; in_func3 = 3'b001; in_mret = 1'b0;
        in_rs1 = 5'd0; in_rs1_val = 64'h1234; in_rd = 5'd7; in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("rst_op_accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_op_valid", 64'(csr_if.valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_csr_valid", 64'(csr_if.valid), 64'd0);
        check("midrst_csr_en", 64'(csr_if.en), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        resp_mute = 1'b0;
        ref_reset();
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || csr_if.valid !== 1'b0) stable = 1'b0;
        end
        check("midrst_quiet", 64'(stable), 64'd1);
        check("midrst_idle", 64'(in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
